// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation control device: register offsets,
// STATUS bit positions and the completion state machine encoding.
package sim_ctrl_pkg;

    localparam logic [7:0] OFF_TOHOST   = 8'h00;
    localparam logic [7:0] OFF_CONSOLE  = 8'h04;
    localparam logic [7:0] OFF_CYCLE_LO = 8'h08;
    localparam logic [7:0] OFF_CYCLE_HI = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;

    localparam int STAT_DONE    = 0;
    localparam int STAT_PASS    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_EMPTY   = 3;
    localparam int STAT_FULL    = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2,
        ST_TMO   = 2'd3
    } state_e;

    function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                                input logic tmo, input logic pass,
                                                input logic done);
        logic [31:0] s;
        s               = '0;
        s[STAT_FULL]    = full;
        s[STAT_EMPTY]   = empty;
        s[STAT_TIMEOUT] = tmo;
        s[STAT_PASS]    = pass;
        s[STAT_DONE]    = done;
        return s;
    endfunction

endpackage

// File: rtl/sim_ctrl_dev_fifo.sv
// Generic synchronous FIFO; data visible on data_o one cycle after a push into empty.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sim_ctrl_dev.sv
// Bus-mapped test-completion, console and cycle-counter device; zero-wait reads.
// Only a CONSOLE write into a full FIFO is stalled (ready_o=0) until a byte drains.
module sim_ctrl_dev
    import sim_ctrl_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] TIMEOUT    = 32'd100000,
    parameter int          ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic [31:0]       rdata_o,
    output logic [7:0]        char_o,
    output logic              char_valid_o,
    input  logic              char_ready_i,
    output logic              done_o,
    output logic              pass_o,
    output logic [30:0]       fail_code_o,
    output logic              timeout_o
);

    state_e       state_q, state_d;
    logic [31:0]  tohost_q, tohost_d;
    logic [63:0]  cycle_q, cycle_d;
    logic [31:0]  cycle_hi_q, cycle_hi_d;

    logic [7:0]   reg_off;
    logic         console_wr, tohost_wr, cycle_lo_rd, xfer, tmo_hit;
    logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]   fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic         unused_ok;

    assign reg_off = 8'({addr_i[ADDR_W-1:2], 2'b00});

    assign fifo_pop   = !fifo_empty && char_ready_i;
    assign console_wr = req_i && we_i && (reg_off == OFF_CONSOLE);
    assign ready_o    = req_i && !(console_wr && fifo_full && !fifo_pop);
    assign xfer       = req_i && ready_o;
    assign fifo_push  = xfer && console_wr;
    assign tohost_wr  = xfer && we_i && (reg_off == OFF_TOHOST);
    assign cycle_lo_rd = xfer && !we_i && (reg_off == OFF_CYCLE_LO);

    assign tmo_hit = (TIMEOUT != 32'd0) && (cycle_q == ({32'd0, TIMEOUT} - 64'd1));

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (wdata_i[7:0]),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign char_valid_o = !fifo_empty;
    assign char_o       = fifo_empty ? 8'h00 : fifo_dout;

    assign done_o      = (state_q == ST_DONE) || (state_q == ST_TMO);
    assign timeout_o   = (state_q == ST_TMO);
    assign pass_o      = (state_q == ST_DONE) && (tohost_q == 32'd1);
    assign fail_code_o = ((state_q == ST_DONE) && (tohost_q != 32'd1)) ? tohost_q[31:1] : '0;

    always_comb begin
        state_d    = state_q;
        tohost_d   = tohost_q;
        cycle_d    = cycle_q + 64'd1;
        cycle_hi_d = cycle_lo_rd ? cycle_q[63:32] : cycle_hi_q;
        unique case (state_q)
            ST_RUN: begin
                // The verdict is latched once; later TOHOST writes cannot rewrite it.
                if (tohost_wr) begin
                    tohost_d = wdata_i;
                    if (wdata_i != 32'd0) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            default: state_d = state_q;
        endcase
        if (tmo_hit && ((state_q == ST_RUN) || (state_q == ST_DRAIN))) state_d = ST_TMO;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            tohost_q   <= '0;
            cycle_q    <= '0;
            cycle_hi_q <= '0;
        end else begin
            state_q    <= state_d;
            tohost_q   <= tohost_d;
            cycle_q    <= cycle_d;
            cycle_hi_q <= cycle_hi_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (req_i && !we_i) begin
            case (reg_off)
                OFF_TOHOST:   rdata_o = tohost_q;
                OFF_CYCLE_LO: rdata_o = cycle_q[31:0];
                OFF_CYCLE_HI: rdata_o = cycle_hi_q;
                OFF_STATUS:   rdata_o = pack_status(fifo_full, fifo_empty, timeout_o,
                                                    pass_o, done_o);
                default:      rdata_o = '0;
            endcase
        end
    end

    assign unused_ok = ^{addr_i[1:0], fifo_count};

endmodule

// File: tb/tb_sim_ctrl_dev.sv
// Directed + randomized bench for sim_ctrl_dev: a byte queue models the console,
// an edge count models the cycle counter; a second instance runs with TIMEOUT=50.
module tb_sim_ctrl_dev;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [4:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        char_ready_i = 1'b0;

    logic        ready, char_valid, done, pass, timeout;
    logic [31:0] rdata;
    logic [7:0]  char_o;
    logic [30:0] fail_code;

    logic        t_ready, t_char_valid, t_done, t_pass, t_timeout;
    logic [31:0] t_rdata;
    logic [7:0]  t_char_o;
    logic [30:0] t_fail_code;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    sim_ctrl_dev u_dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .ready_o(ready), .rdata_o(rdata), .char_o(char_o),
        .char_valid_o(char_valid), .char_ready_i(char_ready_i), .done_o(done),
        .pass_o(pass), .fail_code_o(fail_code), .timeout_o(timeout)
    );

    sim_ctrl_dev #(.TIMEOUT(32'd50)) u_tmo (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .ready_o(t_ready), .rdata_o(t_rdata), .char_o(t_char_o),
        .char_valid_o(t_char_valid), .char_ready_i(char_ready_i), .done_o(t_done),
        .pass_o(t_pass), .fail_code_o(t_fail_code), .timeout_o(t_timeout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: account for what the edge will do, then return at the next negedge.
    task automatic tick();
        #1;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (char_valid && char_ready_i) begin
                check("char_pop_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("char_order", 64'(char_o), 64'(exp_q.pop_front()));
            end
            if (req_i && we_i && ready && addr_i[4:2] == 3'd1) exp_q.push_back(wdata_i[7:0]);
        end
        @(posedge clk);
        cyc = rst ? 0 : cyc + 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_i = 1'b0;
        we_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, output int waited);
        logic acc;
        acc = 1'b0;
        waited = 0;
        req_i = 1'b1;
        we_i = 1'b1;
        addr_i = a;
        wdata_i = d;
        while (!acc && waited < 64) begin
            #1;
            acc = ready;
            if (!acc && waited >= 3) char_ready_i = 1'b1;
            tick();
            if (!acc) waited++;
        end
        req_i = 1'b0;
        we_i = 1'b0;
        if (!acc) check("write_accepted", 64'(acc), 64'd1);
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        req_i = 1'b1;
        we_i = 1'b0;
        addr_i = a;
        #1;
        d = rdata;
        check("read_ready", 64'(ready), 64'd1);
        tick();
        req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] rd;
        int          w, wsum;
        logic [7:0]  b;

        // Reset state and idle counter.
        do_reset();
        check("rst_char_valid", 64'(char_valid), 64'd0);
        check("rst_char_o", 64'(char_o), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_fail_code", 64'(fail_code), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        repeat (10) tick();
        check("idle_done", 64'(done), 64'd0);
        check("idle_char_valid", 64'(char_valid), 64'd0);
        bus_read(5'h08, rd);
        check("cycle_lo", 64'(rd), 64'(cyc - 1));
        bus_read(5'h0C, rd);
        check("cycle_hi", 64'(rd), 64'd0);
        bus_read(5'h10, rd);
        check("status_idle", 64'(rd), 64'h08);
        bus_read(5'h14, rd);
        check("unmapped_read", 64'(rd), 64'd0);

        // "Hi" then pass verdict; done one cycle after the console empties.
        char_ready_i = 1'b0;
        bus_write(5'h04, 32'h0000_0048, w);
        bus_write(5'h04, 32'hFFFF_FF69, w);
        bus_write(5'h00, 32'd1, w);
        check("drain_not_done", 64'(done), 64'd0);
        char_ready_i = 1'b1;
        tick();
        tick();
        check("empty_edge_done", 64'(done), 64'd0);
        tick();
        check("pass_done", 64'(done), 64'd1);
        check("pass_pass", 64'(pass), 64'd1);
        check("pass_fail_code", 64'(fail_code), 64'd0);
        check("hi_drained", 64'(exp_q.size()), 64'd0);

        // Fill to 16, stall the 17th, release with a same-cycle pop.
        do_reset();
        char_ready_i = 1'b0;
        wsum = 0;
        for (int i = 0; i < 16; i++) begin
            bus_write(5'h04, $urandom, w);
            wsum += w;
        end
        check("fill_no_wait", 64'(wsum), 64'd0);
        bus_read(5'h10, rd);
        check("status_full", 64'(rd), 64'h10);
        req_i = 1'b1;
        we_i = 1'b1;
        addr_i = 5'h04;
        wdata_i = $urandom;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("full_stall", 64'(ready), 64'd0);
            tick();
        end
        char_ready_i = 1'b1;
        #1;
        check("full_pop_push", 64'(ready), 64'd1);
        tick();
        req_i = 1'b0;
        we_i = 1'b0;
        check("model_depth_16", 64'(exp_q.size()), 64'd16);

        // Random sink backpressure with wrap-around.
        for (int i = 0; i < 30; i++) begin
            char_ready_i = 1'($urandom_range(0, 1));
            bus_write(5'h04, $urandom, w);
        end
        char_ready_i = 1'b1;
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
        check("random_drained", 64'(exp_q.size()), 64'd0);
        check("random_valid_low", 64'(char_valid), 64'd0);

        // Fail verdict waits for three queued bytes.
        do_reset();
        char_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(5'h04, $urandom, w);
        bus_write(5'h00, 32'h0000_0007, w);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fail_wait_done", 64'(done), 64'd0);
        end
        char_ready_i = 1'b1;
        repeat (3) tick();
        check("fail_empty_valid", 64'(char_valid), 64'd0);
        check("fail_empty_done", 64'(done), 64'd0);
        tick();
        check("fail_done", 64'(done), 64'd1);
        check("fail_pass", 64'(pass), 64'd0);
        check("fail_code", 64'(fail_code), 64'd3);
        bus_write(5'h00, 32'd1, w);
        check("late_pass", 64'(pass), 64'd0);
        check("late_code", 64'(fail_code), 64'd3);
        bus_read(5'h00, rd);
        check("tohost_kept", 64'(rd), 64'd7);
        bus_read(5'h10, rd);
        check("status_done", 64'(rd), 64'h09);

        // Reset while draining with 5 bytes queued.
        do_reset();
        char_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            bus_write(5'h04, {24'd0, b}, w);
        end
        bus_write(5'h00, 32'd1, w);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 64'(char_valid), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        bus_read(5'h10, rd);
        check("mid_rst_status", 64'(rd), 64'h08);

        // Watchdog at cycle 50.
        do_reset();
        repeat (49) tick();
        check("tmo_before", 64'(t_timeout), 64'd0);
        check("tmo_before_done", 64'(t_done), 64'd0);
        tick();
        check("tmo_timeout", 64'(t_timeout), 64'd1);
        check("tmo_done", 64'(t_done), 64'd1);
        check("tmo_pass", 64'(t_pass), 64'd0);
        check("no_tmo_default", 64'(timeout), 64'd0);

        // TOHOST=1 on the same edge as the watchdog.
        do_reset();
        repeat (49) tick();
        bus_write(5'h00, 32'd1, w);
        check("race_timeout", 64'(t_timeout), 64'd1);
        check("race_done", 64'(t_done), 64'd1);
        check("race_pass", 64'(t_pass), 64'd0);
        check("race_fail_code", 64'(t_fail_code), 64'd0);
        tick();
        check("race_ref_done", 64'(done), 64'd1);
        check("race_ref_pass", 64'(pass), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sim_ctrl_dev.md
Name: sim_ctrl_dev

Overview:
- Memory-mapped responder on the tinyriscv data bus that gives the bench one place to watch for test completion, pass/fail and console output.
- The core writes a riscv-tests style "tohost" word and console bytes. The block buffers the bytes, drains them through a valid/ready character port and raises done/pass/fail once the console is empty.
- A free-running cycle counter and a watchdog bound simulation time.
- It sits beside the data memory, selected by the core's address decode.

Parameters:
- FIFO_DEPTH, 16, console byte FIFO entries (power of 2, ≥2)
- TIMEOUT, 32'd100000, cycles after reset before the watchdog fires; 0 disables it
- ADDR_W, 5, byte-address bits decoded inside the block

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_i  in  1  bus request, valid for one transfer
- we_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_W  byte offset; word aligned, bits[1:0] ignored
- wdata_i  in  32  write data
- ready_o  out  1  transfer accepted this cycle
- rdata_o  out  32  read data, valid in the same cycle as ready_o
- char_o  out  8  console byte at the FIFO head
- char_valid_o  out  1  char_o is valid
- char_ready_i  in  1  sink takes the byte on valid & ready
- done_o  out  1  test finished (sticky)
- pass_o  out  1  test passed (sticky, only meaningful with done_o)
- fail_code_o  out  31  tohost[31:1] on failure, 0 otherwise
- timeout_o  out  1  watchdog expired (sticky)

Behaviour:
- Register map (offset):
  - 0x00 TOHOST (W; reads return last write)
  - 0x04 CONSOLE (W; byte = wdata[7:0]; reads return 0)
  - 0x08 CYCLE_LO (R)
  - 0x0C CYCLE_HI (R)
  - 0x10 STATUS (R): {27'b0, fifo_full, fifo_empty, timeout, pass, done}
  - Other offsets: writes ignored, reads 0, ready still given.
- Reset (rst=1 at a clk edge):
  - All outputs 0.
  - FIFO emptied; cycle counter = 0; tohost reg = 0; state = RUN.
  - Applies mid-transfer and mid-drain; any byte in flight is dropped.
- Handshake:
  - ready_o = req_i combinationally, except for a CONSOLE write while the FIFO is full. That write is held (ready_o=0) until a slot frees.
  - A FIFO pop and a push on the same cycle while full: the pop frees a slot, so the write completes that cycle.
  - Side effects occur on the edge where req_i & ready_o.
  - Reads have zero wait states.
- Cycle counter:
  - 64-bit, +1 every cycle from reset, wraps at 2^64.
  - Reading CYCLE_LO latches CYCLE_HI into a shadow register; CYCLE_HI reads return the shadow, giving an atomic LO→HI pair.
- FIFO:
  - Circular buffer with wrap-around pointers plus count.
  - char_valid_o = !empty; pop on char_valid_o & char_ready_i.
  - Push and pop in the same cycle with count between 1 and FIFO_DEPTH-1: count unchanged.
  - Push into an empty FIFO: byte visible on char_o the next cycle (1-cycle latency).
- State machine RUN → DRAIN → DONE, plus TIMEOUT:
  - RUN: a TOHOST write with wdata≠0 stores the word and moves to DRAIN. A write of 0 is stored with no transition.
  - DRAIN: CONSOLE writes are still accepted. When the FIFO is empty, go to DONE.
  - DONE: done_o=1. pass_o = (tohost==1). fail_code_o = tohost[31:1] when tohost≠1 (even values ≠0 count as fail with code tohost[31:1]). DONE is terminal until reset; further TOHOST writes are ignored.
  - TIMEOUT: from RUN or DRAIN when TIMEOUT≠0 and cycle==TIMEOUT-1 at the edge.
    - Sets timeout_o=1, done_o=1, pass_o=0.
    - Terminal; the FIFO keeps draining.
  - A TOHOST write and the timeout on the same edge: timeout wins.

Decomposition:
- Shared package (sim_ctrl_pkg): register offset constants, STATUS bit indices, state encoding.
- One natural sub-module: sync_fifo (parameter DEPTH, WIDTH=8, with full/empty/count). It is generic and reusable for a future UART transmitter.

Test Plan:
- Reset then idle 10 cycles: all outputs 0. Read 0x08 → 10±1; then read 0x0C → 0.
- Write 'H','i' to 0x04 with char_ready_i=1: char_o shows 0x48 then 0x69 on consecutive valid cycles. Then write 1 to 0x00: done_o=1 and pass_o=1 one cycle after the FIFO empties.
- Hold char_ready_i=0 and write 17 bytes (FIFO_DEPTH=16): the 17th write sees ready_o=0 until char_ready_i=1 for one cycle. Order is preserved across pointer wrap.
- Write 0x0000_0007 to 0x00 with 3 bytes queued: done_o stays 0 until the FIFO is empty. Then done_o=1, pass_o=0, fail_code_o=3. A later write of 1 causes no change.
- TIMEOUT=50, no tohost write: at cycle 50, timeout_o=1, done_o=1, pass_o=0. Same-edge TOHOST=1 write still ends with timeout_o=1.
- Assert rst in DRAIN with 5 bytes queued: the next cycle shows char_valid_o=0, done_o=0, STATUS=0x08 (fifo_empty).
